// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus shared by two cache controllers: snoop, optional writeback, memory fetch.
// Optional macro CACHE_TO_CACHE_EN: a snoop hit completes from the snoop word without re-reading memory.
module snoop_bus_arbiter #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        read_miss,
    input  logic [1:0]        write_miss,
    input  logic [1:0]        invalidate,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        grant,
    output logic [1:0]        u_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-3:0] BOCI,
    output logic [1:0]        cpu_search,
    output logic              snoop_inv,
    input  logic [1:0]        cpu_search_found,
    input  logic [DATA_W-1:0] snoop_data0,
    input  logic [DATA_W-1:0] snoop_data1,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              bus_err
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SNOOP, WB, MEMRD, DONE} state_t;
    typedef enum logic [1:0] {REQ_RD, REQ_RDX, REQ_UPGR} req_t;

    state_t            state;
    req_t              req_type;
    req_t              win_type;
    logic              owner;
    logic              rr_ptr;
    logic              winner;
    logic              found;
    logic              tmo;
    logic [1:0]        req;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] other_data;
    logic [TMR_W-1:0]  timer;

    function automatic logic [1:0] onehot(input logic core);
        return core ? 2'b10 : 2'b01;
    endfunction

    assign req = read_miss | write_miss | invalidate;

    // With both cores asking, rr_ptr decides; otherwise req[1] names the sole requester.
    always_comb begin
        winner   = (req == 2'b11) ? rr_ptr : req[1];
        win_addr = winner ? req_addr1 : req_addr0;
        if (write_miss[winner])
            win_type = REQ_RDX;
        else if (invalidate[winner])
            win_type = REQ_UPGR;
        else
            win_type = REQ_RD;
    end

    assign found      = owner ? cpu_search_found[0] : cpu_search_found[1];
    assign other_data = owner ? snoop_data0 : snoop_data1;
    assign tmo        = (timer == TMR_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_type   <= REQ_RD;
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            timer      <= '0;
            grant      <= '0;
            u_rdy      <= '0;
            cpu_search <= '0;
            snoop_inv  <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            bus_err    <= 1'b0;
            BOCI       <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner      <= winner;
                        req_type   <= win_type;
                        mem_addr   <= win_addr;
                        BOCI       <= win_addr[ADDR_W-1:2];
                        grant      <= onehot(winner);
                        cpu_search <= onehot(!winner);
                        snoop_inv  <= (win_type != REQ_RD);
                        state      <= SNOOP;
                    end
                end
                SNOOP: begin
                    cpu_search <= '0;
                    snoop_inv  <= 1'b0;
                    timer      <= '0;
                    if (req_type == REQ_UPGR) begin
                        u_rdy <= onehot(owner);
                        state <= DONE;
                    end else if (found) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= other_data;
                        state     <= WB;
                    end else begin
                        mem_re <= 1'b1;
                        state  <= MEMRD;
                    end
                end
                WB: begin
                    if (mem_rdy) begin
                        mem_we   <= 1'b0;
                        rsp_data <= mem_wdata;
                        timer    <= '0;
`ifdef CACHE_TO_CACHE_EN
                        u_rdy    <= onehot(owner);
                        state    <= DONE;
`else
                        mem_re   <= 1'b1;
                        state    <= MEMRD;
`endif
                    end else if (tmo) begin
                        mem_we   <= 1'b0;
                        bus_err  <= 1'b1;
                        rsp_data <= '0;
                        u_rdy    <= onehot(owner);
                        state    <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                MEMRD: begin
                    // A late mem_rdy on the timeout cycle still wins over the error path.
                    if (mem_rdy) begin
                        mem_re   <= 1'b0;
                        rsp_data <= mem_rdata;
                        u_rdy    <= onehot(owner);
                        state    <= DONE;
                    end else if (tmo) begin
                        mem_re   <= 1'b0;
                        bus_err  <= 1'b1;
                        rsp_data <= '0;
                        u_rdy    <= onehot(owner);
                        state    <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    u_rdy  <= '0;
                    grant  <= '0;
                    rr_ptr <= ~owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Randomised bench for snoop_bus_arbiter against a transaction-level model with a bench-owned memory.
module tb_snoop_bus_arbiter;

    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 16;
    localparam int MEM_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        read_miss = '0;
    logic [1:0]        write_miss = '0;
    logic [1:0]        invalidate = '0;
    logic [ADDR_W-1:0] req_addr0 = '0;
    logic [ADDR_W-1:0] req_addr1 = '0;
    logic [1:0]        grant;
    logic [1:0]        u_rdy;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-3:0] BOCI;
    logic [1:0]        cpu_search;
    logic              snoop_inv;
    logic [1:0]        cpu_search_found = '0;
    logic [DATA_W-1:0] snoop_data0 = '0;
    logic [DATA_W-1:0] snoop_data1 = '0;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_rdy = 1'b0;
    logic              bus_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
    int  mem_latency = 1;
    bit  mem_hang = 1'b0;
    int  mem_cnt = 0;
    int  re_cycles = 0;
    int  we_cycles = 0;

`ifdef CACHE_TO_CACHE_EN
    localparam bit C2C = 1'b1;
`else
    localparam bit C2C = 1'b0;
`endif

    snoop_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .grant(grant), .u_rdy(u_rdy), .rsp_data(rsp_data), .BOCI(BOCI),
        .cpu_search(cpu_search), .snoop_inv(snoop_inv), .cpu_search_found(cpu_search_found),
        .snoop_data0(snoop_data0), .snoop_data1(snoop_data1),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Memory: pulses mem_rdy once a strobe has been held mem_latency cycles, then stores or returns the word.
    always @(negedge clk) begin
        if (mem_rdy) begin
            mem_rdy = 1'b0;
            mem_cnt = 0;
        end
        if (mem_re || mem_we) begin
            mem_cnt++;
            if (mem_re) re_cycles++;
            if (mem_we) we_cycles++;
            if (!mem_hang && mem_cnt >= mem_latency) begin
                mem_rdy = 1'b1;
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
                else        mem_rdata = mem_arr[mem_addr];
            end
        end else begin
            mem_cnt = 0;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (grant == 2'b11 || (mem_re && mem_we)) begin
            errors++;
            $display("[TB] FAIL invariant: grant=%b mem_re=%b mem_we=%b, required grant not 11 and strobes exclusive",
                     grant, mem_re, mem_we);
        end
    end

    function automatic logic [1:0] core_bit(input int core);
        return (core == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request (kind 0=read_miss, 1=write_miss, 2=invalidate) and records what the bus did.
    task automatic run_txn(input int core, input int kind, input logic [ADDR_W-1:0] addr,
                           input logic found, input logic [DATA_W-1:0] sword, input int lat,
                           output logic [1:0] grant_seen, output logic [1:0] search_seen,
                           output logic inv_seen, output logic [ADDR_W-3:0] boci_seen,
                           output logic [1:0] urdy_seen, output logic [DATA_W-1:0] data_seen,
                           output int latency, output logic [1:0] grant_after);
        mem_latency = lat;
        re_cycles = 0;
        we_cycles = 0;
        grant_seen = '0; search_seen = '0; inv_seen = 1'b0; boci_seen = '0;
        urdy_seen = '0; data_seen = '0; latency = -1;
        if (core == 0) req_addr0 = addr; else req_addr1 = addr;
        snoop_data0 = DATA_W'($urandom);
        snoop_data1 = DATA_W'($urandom);
        if (core == 0) snoop_data1 = sword; else snoop_data0 = sword;
        cpu_search_found = 2'($urandom);
        cpu_search_found[1-core] = found;
        case (kind)
            0: read_miss[core] = 1'b1;
            1: write_miss[core] = 1'b1;
            default: invalidate[core] = 1'b1;
        endcase
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (grant_seen == 2'b00 && grant != 2'b00) begin
                grant_seen = grant; search_seen = cpu_search;
                inv_seen = snoop_inv; boci_seen = BOCI;
            end
            if (u_rdy != 2'b00) begin
                urdy_seen = u_rdy; data_seen = rsp_data; latency = n;
                break;
            end
        end
        read_miss = '0; write_miss = '0; invalidate = '0;
        @(negedge clk);
        grant_after = grant;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({grant, u_rdy, cpu_search, snoop_inv, mem_re, mem_we, bus_err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b required 0",
                     {grant, u_rdy, cpu_search, snoop_inv, mem_re, mem_we, bus_err});
        end
        checks++;
        if ({BOCI, mem_addr, mem_wdata, rsp_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: BOCI=%h mem_addr=%h mem_wdata=%h rsp_data=%h required all 0",
                     BOCI, mem_addr, mem_wdata, rsp_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_miss();
        logic [1:0] g, s, u, ga; logic inv; logic [ADDR_W-3:0] b; logic [DATA_W-1:0] d; int lat;
        mem_arr[13'h0014] = 16'hBEEF;
        run_txn(0, 0, 13'h0014, 1'b0, 16'h0, 3, g, s, inv, b, u, d, lat, ga);
        checks++;
        if (g !== 2'b01 || s !== 2'b10 || inv !== 1'b0 || b !== 11'h005) begin
            errors++;
            $display("[TB] FAIL rd_snoop: grant=%b search=%b inv=%b BOCI=%h required 01 10 0 005", g, s, inv, b);
        end
        checks++;
        if (re_cycles != 3 || we_cycles != 0) begin
            errors++;
            $display("[TB] FAIL rd_strobes: re=%0d we=%0d required 3 0", re_cycles, we_cycles);
        end
        checks++;
        if (u !== 2'b01 || d !== 16'hBEEF || lat != 5) begin
            errors++;
            $display("[TB] FAIL rd_result: u_rdy=%b data=%h lat=%0d required 01 BEEF 5", u, d, lat);
        end
        checks++;
        if (ga !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rd_release: grant=%b required 00", ga);
        end
    endtask

    task automatic test_write_miss_hit();
        logic [1:0] g, s, u, ga; logic inv; logic [ADDR_W-3:0] b; logic [DATA_W-1:0] d; int lat;
        mem_arr[13'h0104] = 16'h5555;
        run_txn(1, 1, 13'h0104, 1'b1, 16'h1234, 2, g, s, inv, b, u, d, lat, ga);
        checks++;
        if (g !== 2'b10 || s !== 2'b01 || inv !== 1'b1 || b !== 11'h041) begin
            errors++;
            $display("[TB] FAIL wm_snoop: grant=%b search=%b inv=%b BOCI=%h required 10 01 1 041", g, s, inv, b);
        end
        checks++;
        if (we_cycles != 2 || re_cycles != (C2C ? 0 : 2) || mem_arr[13'h0104] !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL wm_writeback: we=%0d re=%0d mem=%h required 2 %0d 1234",
                     we_cycles, re_cycles, mem_arr[13'h0104], C2C ? 0 : 2);
        end
        checks++;
        if (u !== 2'b10 || d !== 16'h1234 || lat != (C2C ? 4 : 6)) begin
            errors++;
            $display("[TB] FAIL wm_result: u_rdy=%b data=%h lat=%0d required 10 1234 %0d", u, d, lat, C2C ? 4 : 6);
        end
    endtask

    task automatic test_invalidate();
        logic [1:0] g, s, u, ga; logic inv; logic [ADDR_W-3:0] b; logic [DATA_W-1:0] d; int lat;
        run_txn(0, 2, 13'h0008, 1'b1, 16'hAAAA, 1, g, s, inv, b, u, d, lat, ga);
        checks++;
        if (b !== 11'h002 || inv !== 1'b1 || s !== 2'b10) begin
            errors++;
            $display("[TB] FAIL inv_snoop: BOCI=%h inv=%b search=%b required 002 1 10", b, inv, s);
        end
        // IDLE, SNOOP, DONE: u_rdy shows in the third cycle counted from the request.
        checks++;
        if (u !== 2'b01 || lat != 2 || re_cycles != 0 || we_cycles != 0) begin
            errors++;
            $display("[TB] FAIL inv_result: u_rdy=%b lat=%0d re=%0d we=%0d required 01 2 0 0",
                     u, lat, re_cycles, we_cycles);
        end
    endtask

    task automatic test_round_robin();
        int exp_owner = 0;
        bit seen;
        apply_reset();
        mem_latency = 2;
        cpu_search_found = '0;
        req_addr0 = 13'h0100;
        req_addr1 = 13'h0A04;
        read_miss = 2'b11;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(negedge clk);
                seen = (grant != 2'b00);
            end
            checks++;
            if (grant !== core_bit(exp_owner)) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: got %b required %b", k, grant, core_bit(exp_owner));
            end
            seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(negedge clk);
                seen = (u_rdy != 2'b00);
            end
            checks++;
            if (u_rdy !== core_bit(exp_owner) ||
                rsp_data !== mem_arr[(exp_owner == 0) ? req_addr0 : req_addr1]) begin
                errors++;
                $display("[TB] FAIL rr_done%0d: u_rdy=%b data=%h required %b %h", k, u_rdy, rsp_data,
                         core_bit(exp_owner), mem_arr[(exp_owner == 0) ? req_addr0 : req_addr1]);
            end
            @(negedge clk);
            checks++;
            if (grant !== 2'b00) begin
                errors++;
                $display("[TB] FAIL rr_gap%0d: grant=%b required 00", k, grant);
            end
            exp_owner = 1 - exp_owner;
        end
        read_miss = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_same_block();
        logic [ADDR_W-1:0] addr = ADDR_W'($urandom);
        logic [DATA_W-1:0] v = DATA_W'($urandom);
        logic [DATA_W-1:0] w = DATA_W'($urandom);
        int done_cnt = 0;
        apply_reset();
        mem_arr[addr] = v;
        mem_latency = 1;
        cpu_search_found = '0;
        req_addr0 = addr;
        req_addr1 = addr;
        write_miss[0] = 1'b1;
        read_miss[1] = 1'b1;
        for (int n = 0; n < 100 && done_cnt < 2; n++) begin
            @(negedge clk);
            if (u_rdy != 2'b00) begin
                checks++;
                if (done_cnt == 0) begin
                    if (u_rdy !== 2'b01 || rsp_data !== v) begin
                        errors++;
                        $display("[TB] FAIL same_first: u_rdy=%b data=%h required 01 %h", u_rdy, rsp_data, v);
                    end
                    write_miss = '0;
                    cpu_search_found = 2'b01;
                    snoop_data0 = w;
                end else begin
                    if (u_rdy !== 2'b10 || rsp_data !== w) begin
                        errors++;
                        $display("[TB] FAIL same_second: u_rdy=%b data=%h required 10 %h", u_rdy, rsp_data, w);
                    end
                    read_miss = '0;
                end
                done_cnt++;
            end
        end
        read_miss = '0;
        write_miss = '0;
        @(negedge clk);
        checks++;
        if (done_cnt != 2 || mem_arr[addr] !== w) begin
            errors++;
            $display("[TB] FAIL same_mem: completions=%0d mem=%h required 2 %h", done_cnt, mem_arr[addr], w);
        end
    endtask

    task automatic test_random();
        logic [1:0] g, s, u, ga; logic inv; logic [ADDR_W-3:0] b; logic [DATA_W-1:0] d; int lat;
        for (int t = 0; t < 24; t++) begin
            int core = int'($urandom_range(0, 1));
            int kind = int'($urandom_range(0, 2));
            int ml = int'($urandom_range(1, 4));
            logic [ADDR_W-1:0] addr = ADDR_W'($urandom);
            logic hit = 1'($urandom);
            logic [DATA_W-1:0] sw = DATA_W'($urandom);
            logic [DATA_W-1:0] exp_data = hit ? sw : mem_arr[addr];
            int exp_lat = (kind == 2) ? 2 : (!hit ? 2 + ml : (C2C ? 2 + ml : 2 + 2 * ml));
            int exp_re = (kind == 2) ? 0 : (!hit ? ml : (C2C ? 0 : ml));
            int exp_we = (kind != 2 && hit) ? ml : 0;
            run_txn(core, kind, addr, hit, sw, ml, g, s, inv, b, u, d, lat, ga);
            checks++;
            if (g !== core_bit(core) || s !== core_bit(1 - core) || inv !== (kind != 0) ||
                b !== addr[ADDR_W-1:2]) begin
                errors++;
                $display("[TB] FAIL rand%0d_snoop: grant=%b search=%b inv=%b BOCI=%h required %b %b %b %h",
                         t, g, s, inv, b, core_bit(core), core_bit(1 - core), kind != 0, addr[ADDR_W-1:2]);
            end
            checks++;
            if (u !== core_bit(core) || lat != exp_lat || (kind != 2 && d !== exp_data)) begin
                errors++;
                $display("[TB] FAIL rand%0d_result: u_rdy=%b lat=%0d data=%h required %b %0d %h",
                         t, u, lat, d, core_bit(core), exp_lat, exp_data);
            end
            checks++;
            if (re_cycles != exp_re || we_cycles != exp_we || ga !== 2'b00) begin
                errors++;
                $display("[TB] FAIL rand%0d_mem: re=%0d we=%0d grant_after=%b required %0d %0d 00",
                         t, re_cycles, we_cycles, ga, exp_re, exp_we);
            end
        end
    endtask

    task automatic test_reset_mid_txn();
        logic [1:0] g, s, u, ga; logic inv; logic [ADDR_W-3:0] b; logic [DATA_W-1:0] d; int lat;
        bit seen = 1'b0;
        bit stray = 1'b0;
        mem_latency = 6;
        cpu_search_found = '0;
        req_addr0 = 13'h0777;
        read_miss[0] = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = mem_re;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!seen || grant !== 2'b00 || mem_re !== 1'b0 || u_rdy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rst_mid: reached_memrd=%b grant=%b mem_re=%b u_rdy=%b required 1 00 0 00",
                     seen, grant, mem_re, u_rdy);
        end
        read_miss = '0;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (u_rdy != 2'b00) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("[TB] FAIL rst_no_urdy: stray u_rdy seen required none");
        end
        run_txn(0, 0, 13'h0777, 1'b0, 16'h0, 2, g, s, inv, b, u, d, lat, ga);
        checks++;
        if (u !== 2'b01 || d !== mem_arr[13'h0777] || lat != 4) begin
            errors++;
            $display("[TB] FAIL rst_retry: u_rdy=%b data=%h lat=%0d required 01 %h 4", u, d, lat, mem_arr[13'h0777]);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] g, s, u, ga; logic inv; logic [ADDR_W-3:0] b; logic [DATA_W-1:0] d; int lat;
        mem_hang = 1'b1;
        run_txn(1, 0, 13'h0321, 1'b0, 16'h0, 1, g, s, inv, b, u, d, lat, ga);
        checks++;
        if (u !== 2'b10 || d !== '0 || lat != 2 + MEM_TIMEOUT || re_cycles != MEM_TIMEOUT || bus_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tmo_result: u_rdy=%b data=%h lat=%0d re=%0d bus_err=%b required 10 0000 %0d %0d 1",
                     u, d, lat, re_cycles, bus_err, 2 + MEM_TIMEOUT, MEM_TIMEOUT);
        end
        mem_hang = 1'b0;
        run_txn(0, 0, 13'h0040, 1'b0, 16'h0, 1, g, s, inv, b, u, d, lat, ga);
        checks++;
        if (bus_err !== 1'b1 || u !== 2'b01 || d !== mem_arr[13'h0040]) begin
            errors++;
            $display("[TB] FAIL tmo_sticky: bus_err=%b u_rdy=%b data=%h required 1 01 %h",
                     bus_err, u, d, mem_arr[13'h0040]);
        end
        apply_reset();
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tmo_clear: bus_err=%b required 0", bus_err);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem_arr[i] = DATA_W'($urandom);
        test_reset();
        test_read_miss();
        test_write_miss_hit();
        test_invalidate();
        test_round_robin();
        test_same_block();
        test_random();
        test_reset_mid_txn();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shared snoop bus stage directly downstream of the two per-core cache controllers.
- Consumes each controller's read_miss / write_miss / invalidate requests and arbitrates them round-robin.
- Broadcasts the winning block address to the other core's cache as BOCI/cpu_search, collects the snoop result, and fetches from unified memory when needed.
- Returns the requested word and the grant / u_rdy handshake to the requesting controller.

Parameters:
- ADDR_W, 13, word address width (block index = ADDR_W-2 = 11 bits).
- DATA_W, 16, data word width.
- MEM_TIMEOUT, 64, cycles to wait for mem_rdy before sticky error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- read_miss  in  2  per-core BusRd request (bit i = core i)
- write_miss  in  2  per-core BusRdX request
- invalidate  in  2  per-core BusUpgr request
- req_addr0  in  ADDR_W  core 0 request word address
- req_addr1  in  ADDR_W  core 1 request word address
- grant  out  2  one-hot bus ownership
- u_rdy  out  2  one-cycle completion pulse to owner
- rsp_data  out  DATA_W  returned word, valid while u_rdy
- BOCI  out  ADDR_W-2  snooped block index to non-owner
- cpu_search  out  2  snoop strobe to the non-owner core
- snoop_inv  out  1  snoop is invalidating (BusRdX/BusUpgr)
- cpu_search_found  in  2  non-owner holds block MODIFIED
- snoop_data0  in  DATA_W  core 0 snoop word (send_other_proc_data)
- snoop_data1  in  DATA_W  core 1 snoop word
- mem_re  out  1  unified memory read strobe
- mem_we  out  1  unified memory write strobe (snoop writeback)
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  writeback word
- mem_rdata  in  DATA_W  memory read word
- mem_rdy  in  1  memory completion pulse
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; grant=0, u_rdy=0, cpu_search=0, snoop_inv=0, mem_re=0, mem_we=0, bus_err=0.
  - BOCI, mem_addr, mem_wdata, rsp_data = 0; rr_ptr=0 (core 0 favoured).
  - Reset mid-transaction aborts it; no u_rdy is issued.
- Request per core: req_i = read_miss[i] | write_miss[i] | invalidate[i]. Type priority within a core: write_miss > invalidate > read_miss.
- Requests are levels; a controller holds its request until it sees u_rdy.
- IDLE:
  - If any req_i, pick the winner: if both request, the winner is core rr_ptr; else the sole requester.
  - Latch the owner, type and address (addr[ADDR_W-1:2] -> BOCI).
  - Assert grant[owner] from the next cycle; go to SNOOP.
- SNOOP (exactly 1 cycle):
  - cpu_search[~owner]=1; snoop_inv=1 for write_miss/invalidate.
  - Sample cpu_search_found[~owner].
  - invalidate -> DONE.
  - found -> WB.
  - else -> MEMRD.
- WB:
  - mem_we=1 with mem_wdata = snoop word of non-owner and mem_addr = latched address; hold until mem_rdy.
  - Capture the word as rsp_data, then -> MEMRD.
  - With CACHE_TO_CACHE_EN, go to DONE instead.
- MEMRD:
  - mem_re=1 held until mem_rdy; capture mem_rdata into rsp_data; -> DONE.
- DONE (1 cycle):
  - u_rdy[owner]=1, grant still asserted.
  - Next cycle: grant=0, rr_ptr=~owner, -> IDLE. A new grant is issued no sooner than 1 idle cycle later.
- Timeout:
  - A counter increments in WB/MEMRD and clears on state entry.
  - Reaching MEM_TIMEOUT sets bus_err (sticky until rst), forces DONE with rsp_data=0.
- mem_re and mem_we are never simultaneously high.
- grant is always one-hot or zero.
- Requests arriving while busy wait; no request is dropped.
- Both cores requesting the same block: serialized, second one snoops the first's now-valid copy.
- mem_rdy arriving the same cycle the strobe first asserts is accepted (zero wait).

Optional Feature:
- CACHE_TO_CACHE_EN:
  - Defined: on a snoop hit the WB state completes the transaction directly from the snoop word, skipping MEMRD and saving one memory access. The writeback still occurs.
  - Undefined: the snoop hit always writes back, then re-reads memory (WB -> MEMRD).

Test Plan:
- rst=1 then core 0 read_miss, addr 0x0014, found=0, mem_rdata=0xBEEF with mem_rdy after 3 cycles -> grant=01, cpu_search=10, mem_re high 3 cycles, u_rdy=01 with rsp_data=0xBEEF.
- Core 1 write_miss addr 0x0104, core 0 found=1, snoop_data0=0x1234 -> snoop_inv=1, mem_we with mem_wdata=0x1234, addr 0x0104. u_rdy=10 with rsp_data=0x1234 (memory reread without the macro, skipped with it).
- Core 0 invalidate addr 0x0008 -> BOCI=0x002, snoop_inv=1, no mem strobe, u_rdy=01 three cycles after the request.
- Both cores read_miss continuously after reset -> grants alternate 01,10,01,10. Never 11.
- mem_rdy never asserted, MEM_TIMEOUT=64 -> bus_err=1 after 64 cycles, u_rdy with rsp_data=0, bus_err stays high until rst.
- rst asserted during MEMRD -> next cycle grant=0, mem_re=0, no u_rdy; a re-requested transaction completes normally.
